// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe
// Execute/write-back slice: NREGS x XLEN register file (x0 reads as zero),
// 8-function ALU, one registered write-back stage and a WB-to-operand bypass
// so that a result is usable by the very next operation.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        an operation is presented this cycle
//   RegWrite        the operation writes rd
//   ALUsrc          1: second ALU operand is ImmOp, 0: rs2 operand
//   ALUctrl         ALU function (add/sub/and/or/xor/slt/sll/srl)
//   rs1, rs2, rd    source and destination register addresses
//   ImmOp           immediate operand
//   EQ, LT          op1 == op2 and signed op1 < op2 (combinational)
//   wb_valid        write-back stage holds a pending register write
//   wb_rd, wb_data  write-back destination and registered ALU result
//   a0              architectural contents of register A0_IDX
module alu_regfile_pipe #(
  parameter int  XLEN   = 32,
  parameter int  NREGS  = 32,
  parameter int  A0_IDX = 10,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            RegWrite,
  input  logic            ALUsrc,
  input  logic [2:0]      ALUctrl,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] ImmOp,
  output logic            EQ,
  output logic            LT,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] a0
);

  localparam int              SW      = $clog2(XLEN);
  localparam logic [AW-1:0]   X0_ADDR = {AW{1'b0}};
  localparam logic [AW-1:0]   A0_ADDR = AW'(A0_IDX);
  localparam logic [XLEN-1:0] ZERO_W  = {XLEN{1'b0}};

  logic [XLEN-1:0] rf_q [NREGS];

  logic            wb_valid_q, wb_valid_d;
  logic [AW-1:0]   wb_rd_q,    wb_rd_d;
  logic [XLEN-1:0] wb_data_q,  wb_data_d;

  logic [XLEN-1:0] op1_s, op2_s, alu_op2_s, alu_res_s;
  logic            lt_s;

  // Operand fetch: x0 is forced to zero, otherwise the pending WB value
  // overrides the (not yet committed) register file entry.
  always_comb begin
    op1_s = ZERO_W;
    op2_s = ZERO_W;
    if (rs1 == X0_ADDR) begin
      op1_s = ZERO_W;
    end else if (wb_valid_q && (wb_rd_q == rs1)) begin
      op1_s = wb_data_q;
    end else begin
      op1_s = rf_q[rs1];
    end
    if (rs2 == X0_ADDR) begin
      op2_s = ZERO_W;
    end else if (wb_valid_q && (wb_rd_q == rs2)) begin
      op2_s = wb_data_q;
    end else begin
      op2_s = rf_q[rs2];
    end
  end

  assign alu_op2_s = ALUsrc ? ImmOp : op2_s;
  assign lt_s      = $signed(op1_s) < $signed(alu_op2_s);
  assign EQ        = (op1_s == alu_op2_s);
  assign LT        = lt_s;

  // ALU; shifts use only the low SW bits of the second operand.
  always_comb begin
    alu_res_s = ZERO_W;
    case (ALUctrl)
      3'b000:  alu_res_s = op1_s + alu_op2_s;
      3'b001:  alu_res_s = op1_s - alu_op2_s;
      3'b010:  alu_res_s = op1_s & alu_op2_s;
      3'b011:  alu_res_s = op1_s | alu_op2_s;
      3'b100:  alu_res_s = op1_s ^ alu_op2_s;
      3'b101:  alu_res_s = {{(XLEN-1){1'b0}}, lt_s};
      3'b110:  alu_res_s = op1_s << alu_op2_s[SW-1:0];
      3'b111:  alu_res_s = op1_s >> alu_op2_s[SW-1:0];
      default: alu_res_s = ZERO_W;
    endcase
  end

  // Next write-back stage contents; rd/data follow the input even when no
  // write is staged, only the valid bit gates the commit.
  always_comb begin
    wb_valid_d = in_valid && RegWrite && (rd != X0_ADDR);
    wb_rd_d    = rd;
    wb_data_d  = alu_res_s;
  end

  // Register file commit and write-back stage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= ZERO_W;
      end
      wb_valid_q <= 1'b0;
      wb_rd_q    <= X0_ADDR;
      wb_data_q  <= ZERO_W;
    end else begin
      if (wb_valid_q) begin
        rf_q[wb_rd_q] <= wb_data_q;
      end
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign a0       = rf_q[A0_ADDR];

endmodule

// File: doc/alu_regfile_pipe.md
Name: alu_regfile_pipe

Overview:
Parametrised successor to the single-cycle ALU/register-file datapath. It holds an XLEN-wide, NREGS-entry register file with x0 hardwired to zero and an 8-function ALU. Every ALU result passes through a registered write-back stage, and a WB-to-operand bypass hides the one-cycle write latency. It sits in the execute/write-back slice of the RV32I core, fed by decode and feeding branch logic (EQ/LT) and the a0 debug output.

Parameters:
XLEN, 32, datapath width in bits (≥8, power of 2)
NREGS, 32, register count (power of 2, ≥2)
AW, $clog2(NREGS), register address width (derived, not overridden)
A0_IDX, 10, register index mirrored on a0

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operation presented this cycle
RegWrite  input  1  operation writes rd
ALUsrc  input  1  1: op2 = ImmOp, 0: op2 = rs2 operand
ALUctrl  input  3  ALU function select
rs1  input  AW  source register 1 address
rs2  input  AW  source register 2 address
rd  input  AW  destination address
ImmOp  input  XLEN  immediate operand
EQ  output  1  op1 == op2 (after mux, after bypass), combinational
LT  output  1  op1 < op2 signed, combinational
wb_valid  output  1  write-back stage holds a pending write
wb_rd  output  AW  write-back destination
wb_data  output  XLEN  write-back data (registered ALU result)
a0  output  XLEN  architectural contents of register A0_IDX

Behaviour:
- Reset (rst=1 at edge): all NREGS entries := 0; wb_valid := 0; wb_rd := 0; wb_data := 0. A pending WB write in the same cycle is discarded. Reset wins over every other event. After reset, a0 = 0.
- Operand read (combinational, cycle N):
  - rawX = RF[rsX].
  - If wb_valid && wb_rd == rsX && rsX != 0, opX = wb_data (bypass); else opX = rawX.
  - rsX == 0 always yields 0.
- op2 mux: ALUop2 = ALUsrc ? ImmOp : op2. ALUop1 = op1.
- ALUctrl encoding:
  - 000 add; 001 sub (op1 - op2)
  - 010 and; 011 or; 100 xor
  - 101 slt (signed; result 1 or 0, zero-extended)
  - 110 sll; 111 srl (logical)
  - Shift amount is ALUop2[$clog2(XLEN)-1:0]; upper bits are ignored. Add/sub wrap modulo 2^XLEN.
- EQ and LT derive from ALUop1/ALUop2 irrespective of in_valid.
- Write-back register (edge ending cycle N, rst=0):
  - wb_valid := in_valid && RegWrite && (rd != 0)
  - wb_rd := rd; wb_data := ALU result
  - wb_rd and wb_data update even when wb_valid goes 0 (value is don't-care).
- Register-file commit: at the same edge, if wb_valid is currently 1, RF[wb_rd] := wb_data. A result computed in cycle N is architecturally visible from cycle N+2; cycle N+1 sees it through the bypass.
- Back-to-back writes to the same rd: the younger result wins. Bypass always selects the WB-stage (most recent) value.
- Writes to x0 are never committed, and x0 is never bypassed.
- a0 = RF[A0_IDX], architectural value, no bypass. It lags a write to A0_IDX by two cycles relative to issue.
- in_valid=0: no new write is staged. A pending WB write still commits.

Test Plan:
- Reset: rst=1 one cycle after random RF writes → all reads 0, a0=0, wb_valid=0.
- Bypass: cycle0 addi x1,x0,5 (ALUsrc=1, ALUctrl=000, Imm=5); cycle1 add x2,x1,x1 → cycle1 op1=op2=5 via bypass, EQ=1; cycle2 wb_data=10; a0 unaffected; RF[2]=10 visible at cycle3.
- x0 protection: addi x0,x0,7 then add x3,x0,x0 → wb_valid=0 after first op; x3=0.
- ALU functions: op1=0xFFFFFFFF, Imm=1:
  - sub → 0xFFFFFFFE
  - slt → 1 (−1 < 1)
  - srl → 0x7FFFFFFF
  - sll with Imm=0x21 → shift by 1 → 0xFFFFFFFE
  - add → 0 (wrap)
- a0 path: addi x10,x0,0x2A at cycle0 → a0=0 at cycle1, a0=0x2A at cycle2.
- Reset mid-operation: issue addi x5,x0,9, assert rst next cycle → x5 reads 0 after reset, no commit; then NREGS=16, XLEN=16 build repeats the bypass test with AW=4.
